// File: rtl/lfsr_draw_ctrl.sv
// Draw controller: arbitrates two requesters, spins an external LFSR, then
// captures and validates four numbers (range + uniqueness) with bounded retries.
module lfsr_draw_ctrl #(
  parameter int SPIN_CYCLES = 16,
  parameter int MAX_NUM     = 99,
  parameter int MAX_RETRY   = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  req_i,
  input  logic [6:0]  lfsr_num_0,
  input  logic [6:0]  lfsr_num_1,
  input  logic [6:0]  lfsr_num_2,
  input  logic [6:0]  lfsr_num_3,
  output logic        lfsr_lock_o,
  output logic [1:0]  ack_o,
  output logic [27:0] draw_o,
  output logic        draw_ok_o,
  output logic        draw_err_o,
  output logic        busy_o,
  output logic        owner_o,
  output logic [2:0]  dbg_state_o
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SPIN   = 3'd1;
  localparam logic [2:0] SETTLE = 3'd2;
  localparam logic [2:0] CHECK  = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  localparam int SPIN_W  = $clog2(SPIN_CYCLES + 1);
  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [SPIN_W-1:0]  SPIN_LAST = SPIN_W'(SPIN_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
  localparam logic [6:0]         MAX_V     = 7'(MAX_NUM);

  logic [2:0]         state_q, state_d;
  logic [SPIN_W-1:0]  spin_cnt_q, spin_cnt_d;
  logic [RETRY_W-1:0] retry_cnt_q, retry_cnt_d;
  logic               owner_q, owner_d;
  logic               last_owner_q, last_owner_d;
  logic [27:0]        cand_q, cand_d;
  logic [27:0]        draw_q, draw_d;
  logic               ok_q, ok_d;
  logic               err_q, err_d;
  logic               lock_q, lock_d;
  logic [1:0]         ack_q, ack_d;
  logic               busy_q, busy_d;

  logic       gnt;
  logic       cand_valid;
  logic [6:0] c0, c1, c2, c3;

  assign c0 = cand_q[6:0];
  assign c1 = cand_q[13:7];
  assign c2 = cand_q[20:14];
  assign c3 = cand_q[27:21];

  assign cand_valid = (c0 <= MAX_V) && (c1 <= MAX_V) && (c2 <= MAX_V) && (c3 <= MAX_V) &&
                      (c0 != c1) && (c0 != c2) && (c0 != c3) &&
                      (c1 != c2) && (c1 != c3) && (c2 != c3);

  // With both requesting, the one that did not win last time gets the grant.
  always_comb begin
    gnt = req_i[1];
    if (req_i == 2'b11) gnt = ~last_owner_q;
  end

  always_comb begin
    state_d      = state_q;
    spin_cnt_d   = spin_cnt_q;
    retry_cnt_d  = retry_cnt_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cand_d       = cand_q;
    draw_d       = draw_q;
    ok_d         = ok_q;
    err_d        = err_q;
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          owner_d     = gnt;
          spin_cnt_d  = '0;
          retry_cnt_d = '0;
          ok_d        = 1'b0;
          err_d       = 1'b0;
          state_d     = SPIN;
        end
      end
      SPIN: begin
        spin_cnt_d = spin_cnt_q + SPIN_W'(1);
        if (spin_cnt_q == SPIN_LAST) state_d = SETTLE;
      end
      SETTLE: begin
        cand_d  = {lfsr_num_3, lfsr_num_2, lfsr_num_1, lfsr_num_0};
        state_d = CHECK;
      end
      CHECK: begin
        if (cand_valid) begin
          draw_d  = cand_q;
          ok_d    = 1'b1;
          state_d = DONE;
        end else if (retry_cnt_q < RETRY_MAX) begin
          retry_cnt_d = retry_cnt_q + RETRY_W'(1);
          spin_cnt_d  = '0;
          state_d     = SPIN;
        end else begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        last_owner_d = owner_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    lock_d = (state_d != SPIN);
    busy_d = (state_d != IDLE);
    ack_d  = 2'b00;
    if (state_d == DONE) ack_d = owner_d ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      spin_cnt_q   <= '0;
      retry_cnt_q  <= '0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      cand_q       <= '0;
      draw_q       <= '0;
      ok_q         <= 1'b0;
      err_q        <= 1'b0;
      lock_q       <= 1'b1;
      ack_q        <= 2'b00;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      spin_cnt_q   <= spin_cnt_d;
      retry_cnt_q  <= retry_cnt_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cand_q       <= cand_d;
      draw_q       <= draw_d;
      ok_q         <= ok_d;
      err_q        <= err_d;
      lock_q       <= lock_d;
      ack_q        <= ack_d;
      busy_q       <= busy_d;
    end
  end

  assign lfsr_lock_o = lock_q;
  assign ack_o       = ack_q;
  assign draw_o      = draw_q;
  assign draw_ok_o   = ok_q;
  assign draw_err_o  = err_q;
  assign busy_o      = busy_q;
  assign owner_o     = owner_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lfsr_draw_ctrl.sv
// Directed bench for lfsr_draw_ctrl: a table of single draws with
// hand-computed latency/results, plus arbitration, toggle and reset sequences.
module tb_lfsr_draw_ctrl;

  localparam logic [2:0] ST_SPIN = 3'd1;
  localparam logic [2:0] ST_DONE = 3'd4;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  req_i;
  logic [6:0]  lfsr_num_0, lfsr_num_1, lfsr_num_2, lfsr_num_3;
  logic        lfsr_lock_o;
  logic [1:0]  ack_o;
  logic [27:0] draw_o;
  logic        draw_ok_o, draw_err_o, busy_o, owner_o;
  logic [2:0]  dbg_state_o;

  int n_vec = 0;
  int n_err = 0;
  int viol  = 0;

  lfsr_draw_ctrl #(.SPIN_CYCLES(16), .MAX_NUM(99), .MAX_RETRY(3)) dut (
    .clock(clock), .reset(reset), .req_i(req_i),
    .lfsr_num_0(lfsr_num_0), .lfsr_num_1(lfsr_num_1),
    .lfsr_num_2(lfsr_num_2), .lfsr_num_3(lfsr_num_3),
    .lfsr_lock_o(lfsr_lock_o), .ack_o(ack_o), .draw_o(draw_o),
    .draw_ok_o(draw_ok_o), .draw_err_o(draw_err_o), .busy_o(busy_o),
    .owner_o(owner_o), .dbg_state_o(dbg_state_o)
  );

  always #5 clock = ~clock;

  // Protocol invariants checked every cycle; summarised as one comparison.
  always @(negedge clock) begin
    if (ack_o == 2'b11) viol++;
    if (ack_o != 2'b00 && dbg_state_o != ST_DONE) viol++;
    if (!lfsr_lock_o && dbg_state_o != ST_SPIN) viol++;
  end

  typedef struct {
    logic [1:0]  req;
    logic [27:0] c1;
    logic [27:0] c2;
    int          exp_cyc;
    logic [1:0]  exp_ack;
    int          exp_low;
    logic [27:0] exp_draw;
    logic        exp_ok;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_lfsr(input logic [27:0] c);
    lfsr_num_0 = c[6:0];
    lfsr_num_1 = c[13:7];
    lfsr_num_2 = c[20:14];
    lfsr_num_3 = c[27:21];
  endtask

  task automatic wait_ack(input int budget, output int cyc, output logic [1:0] got);
    cyc = -1;
    got = 2'b00;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (ack_o != 2'b00) begin
        cyc = i;
        got = ack_o;
        break;
      end
    end
  endtask

  task automatic no_ack_window(input string name, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (ack_o != 2'b00 || busy_o) seen++;
    end
    chk(name, seen, 0);
  endtask

  initial begin
    int          cyc, low, owner_bad;
    logic [1:0]  got;
    logic [1:0]  acks[5];
    logic [1:0]  tog[6];
    bit          done;

    vecs[0] = '{2'b01, {7'd99,7'd42,7'd17,7'd5}, {7'd99,7'd42,7'd17,7'd5},
                19, 2'b01, 16, {7'd99,7'd42,7'd17,7'd5}, 1'b1, 1'b0};
    vecs[1] = '{2'b10, {7'd8,7'd7,7'd3,7'd3}, {7'd4,7'd3,7'd2,7'd1},
                37, 2'b10, 32, {7'd4,7'd3,7'd2,7'd1}, 1'b1, 1'b0};
    vecs[2] = '{2'b01, {7'd3,7'd2,7'd1,7'd120}, {7'd3,7'd120,7'd1,7'd2},
                73, 2'b01, 64, {7'd4,7'd3,7'd2,7'd1}, 1'b0, 1'b1};
    vecs[3] = '{2'b10, {7'd97,7'd98,7'd99,7'd0}, {7'd97,7'd98,7'd99,7'd0},
                19, 2'b10, 16, {7'd97,7'd98,7'd99,7'd0}, 1'b1, 1'b0};
    vecs[4] = '{2'b01, {7'd3,7'd2,7'd1,7'd100}, {7'd3,7'd2,7'd1,7'd0},
                37, 2'b01, 32, {7'd3,7'd2,7'd1,7'd0}, 1'b1, 1'b0};
    vecs[5] = '{2'b01, {7'd7,7'd8,7'd9,7'd7}, {7'd40,7'd30,7'd20,7'd10},
                37, 2'b01, 32, {7'd40,7'd30,7'd20,7'd10}, 1'b1, 1'b0};

    reset = 1'b1;
    req_i = 2'b00;
    set_lfsr({7'd4,7'd3,7'd2,7'd1});
    tick();
    tick();
    chk("rst_lock",  lfsr_lock_o, 1);
    chk("rst_ack",   ack_o, 0);
    chk("rst_draw",  draw_o, 0);
    chk("rst_ok",    draw_ok_o, 0);
    chk("rst_err",   draw_err_o, 0);
    chk("rst_busy",  busy_o, 0);
    chk("rst_owner", owner_o, 0);
    reset = 1'b0;
    tick();

    // Table: one pulsed request per record, candidate switches after first capture.
    foreach (vecs[v]) begin
      req_i = vecs[v].req;
      set_lfsr(vecs[v].c1);
      cyc  = 0;
      low  = 0;
      done = 0;
      got  = 2'b00;
      while (!done && cyc < 200) begin
        tick();
        cyc++;
        if (cyc == 1) req_i = 2'b00;
        if (cyc == 18) set_lfsr(vecs[v].c2);
        if (!lfsr_lock_o) low++;
        if (ack_o != 2'b00) begin
          done = 1;
          got  = ack_o;
        end
      end
      if (!done) cyc = -1;
      chk($sformatf("v%0d_ack_cycle", v), cyc, vecs[v].exp_cyc);
      chk($sformatf("v%0d_ack", v), got, vecs[v].exp_ack);
      chk($sformatf("v%0d_lock_low", v), low, vecs[v].exp_low);
      tick();
      chk($sformatf("v%0d_draw", v), draw_o, vecs[v].exp_draw);
      chk($sformatf("v%0d_ok", v), draw_ok_o, vecs[v].exp_ok);
      chk($sformatf("v%0d_err", v), draw_err_o, vecs[v].exp_err);
      chk($sformatf("v%0d_busy", v), busy_o, 0);
    end

    // Toggling req mid-draw must not change the owner or add acks.
    tog = '{2'b10, 2'b11, 2'b00, 2'b10, 2'b11, 2'b00};
    set_lfsr({7'd4,7'd3,7'd2,7'd1});
    req_i = 2'b01;
    owner_bad = 0;
    cyc = -1;
    got = 2'b00;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (owner_o != 1'b0) owner_bad++;
      req_i = tog[i % 6];
      if (ack_o != 2'b00) begin
        cyc = i;
        got = ack_o;
        req_i = 2'b00;
        break;
      end
    end
    chk("tog_owner", owner_bad, 0);
    chk("tog_ack", got, 2'b01);
    chk("tog_ack_cycle", cyc, 19);
    tick();
    no_ack_window("tog_single_ack", 30);

    // Reset in the middle of SPIN.
    req_i = 2'b01;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 1) req_i = 2'b00;
    end
    chk("mid_busy_pre", busy_o, 1);
    reset = 1'b1;
    tick();
    chk("mid_busy", busy_o, 0);
    chk("mid_lock", lfsr_lock_o, 1);
    chk("mid_ack",  ack_o, 0);
    chk("mid_draw", draw_o, 0);
    chk("mid_ok",   draw_ok_o, 0);
    reset = 1'b0;
    no_ack_window("mid_no_ack", 30);

    // Both held from reset: alternate; then one held alone keeps winning.
    req_i = 2'b11;
    for (int k = 0; k < 5; k++) begin
      if (k == 3) req_i = 2'b01;
      wait_ack(100, cyc, got);
      acks[k] = got;
      if (k == 2) req_i = 2'b01;
    end
    req_i = 2'b00;
    chk("rr_ack0", acks[0], 2'b01);
    chk("rr_ack1", acks[1], 2'b10);
    chk("rr_ack2", acks[2], 2'b01);
    chk("hold_ack3", acks[3], 2'b01);
    chk("hold_ack4", acks[4], 2'b01);
    tick();
    tick();
    chk("final_idle", busy_o, 0);
    chk("protocol_viol", viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
